// File: rtl/updown_mod_counter_if.sv
// Control and status bundle for updown_mod_counter.
// The master drives the controls and watches the count; the counter is the slave.
interface updown_mod_counter_if #(
    parameter int DATA_WIDTH = 8,
    parameter int WRAP_W     = 4
);
    logic                  enable;
    logic                  up_dn;
    logic                  sat_mode;
    logic                  clear;
    logic                  load;
    logic [DATA_WIDTH-1:0] load_val;
    logic [DATA_WIDTH-1:0] max_val;
    logic [DATA_WIDTH-1:0] count;
    logic                  at_max;
    logic                  at_min;
    logic                  tc;
    logic [WRAP_W-1:0]     wraps;

    modport master (
        output enable, up_dn, sat_mode, clear, load, load_val, max_val,
        input  count, at_max, at_min, tc, wraps
    );

    modport slave (
        input  enable, up_dn, sat_mode, clear, load, load_val, max_val,
        output count, at_max, at_min, tc, wraps
    );
endinterface

// File: rtl/updown_mod_counter.sv
// Up/down modulo counter with run-time limit, wrap or saturate mode,
// clear/load, a registered terminal-count pulse and a saturating wrap counter.
module updown_mod_counter #(
    parameter int                 DATA_WIDTH = 8,
    parameter logic [DATA_WIDTH-1:0] RESET_VAL = '0,
    parameter int                 WRAP_W     = 4
) (
    input logic              clk,
    input logic              rst,
    updown_mod_counter_if.slave bus
);
    logic [DATA_WIDTH-1:0] count_q;
    logic                  tc_q;
    logic [WRAP_W-1:0]     wraps_q;

    assign bus.count  = count_q;
    assign bus.tc     = tc_q;
    assign bus.wraps  = wraps_q;
    assign bus.at_max = (count_q == bus.max_val);
    assign bus.at_min = (count_q == '0);

    // tc defaults low every cycle; only a wrap or a saturating arrival raises it.
    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= RESET_VAL;
            tc_q    <= 1'b0;
            wraps_q <= '0;
        end else begin
            tc_q <= 1'b0;
            if (bus.clear) begin
                count_q <= '0;
            end else if (bus.load) begin
                count_q <= (bus.load_val > bus.max_val) ? bus.max_val : bus.load_val;
            end else if (bus.enable) begin
                if (count_q > bus.max_val) begin
                    count_q <= bus.max_val;
                end else if (bus.up_dn) begin
                    if (count_q == bus.max_val) begin
                        if (!bus.sat_mode) begin
                            count_q <= '0;
                            tc_q    <= 1'b1;
                            if (wraps_q != '1)
                                wraps_q <= wraps_q + WRAP_W'(1);
                        end
                    end else begin
                        count_q <= count_q + DATA_WIDTH'(1);
                        if (bus.sat_mode && (count_q == bus.max_val - DATA_WIDTH'(1)))
                            tc_q <= 1'b1;
                    end
                end else begin
                    if (count_q == '0) begin
                        if (!bus.sat_mode) begin
                            count_q <= bus.max_val;
                            tc_q    <= 1'b1;
                            if (wraps_q != '1)
                                wraps_q <= wraps_q + WRAP_W'(1);
                        end
                    end else begin
                        count_q <= count_q - DATA_WIDTH'(1);
                        if (bus.sat_mode && (count_q == DATA_WIDTH'(1)))
                            tc_q <= 1'b1;
                    end
                end
            end
        end
    end
endmodule

// File: tb/tb_updown_mod_counter.sv
// Self-checking bench for updown_mod_counter: directed scenarios plus a
// randomized run compared against an arithmetic reference model.
module tb_updown_mod_counter;
    localparam int DW      = 8;
    localparam int WW      = 4;
    localparam int WRAPMAX = (1 << WW) - 1;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    int m_count;
    int m_tc;
    int m_wraps;

    updown_mod_counter_if #(.DATA_WIDTH(DW), .WRAP_W(WW)) bus ();

    updown_mod_counter #(.DATA_WIDTH(DW), .RESET_VAL(8'd0), .WRAP_W(WW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    // Next state from the behavioural rules: modulo arithmetic for wrap, clamping for saturate.
    task automatic model_step;
        int mx, nxt, target;
        mx = int'(bus.max_val);
        if (rst) begin
            m_count = 0; m_tc = 0; m_wraps = 0;
        end else begin
            m_tc = 0;
            if (bus.clear) begin
                m_count = 0;
            end else if (bus.load) begin
                m_count = (int'(bus.load_val) < mx) ? int'(bus.load_val) : mx;
            end else if (bus.enable) begin
                if (m_count > mx) begin
                    m_count = mx;
                end else if (bus.sat_mode) begin
                    target = bus.up_dn ? mx : 0;
                    if (bus.up_dn) nxt = (m_count + 1 > mx) ? mx : m_count + 1;
                    else           nxt = (m_count - 1 < 0) ? 0 : m_count - 1;
                    m_tc    = (nxt != m_count && nxt == target) ? 1 : 0;
                    m_count = nxt;
                end else begin
                    if (bus.up_dn) begin
                        m_tc    = (m_count == mx) ? 1 : 0;
                        m_count = (m_count + 1) % (mx + 1);
                    end else begin
                        m_tc    = (m_count == 0) ? 1 : 0;
                        m_count = (m_count + mx) % (mx + 1);
                    end
                    if (m_tc == 1 && m_wraps < WRAPMAX) m_wraps++;
                end
            end
        end
    endtask

    task automatic tick;
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic idle_inputs;
        bus.enable = 1'b0; bus.up_dn = 1'b1; bus.sat_mode = 1'b0;
        bus.clear = 1'b0; bus.load = 1'b0; bus.load_val = '0; bus.max_val = 8'd9;
    endtask

    task automatic test_reset;
        idle_inputs();
        rst = 1'b1;
        tick(); tick();
        rst = 1'b0;
        checks++; if (bus.count !== 8'd0) begin errors++; $display("[TB] FAIL reset_count got %0d want 0", bus.count); end
        checks++; if (bus.tc !== 1'b0) begin errors++; $display("[TB] FAIL reset_tc got %b want 0", bus.tc); end
        checks++; if (bus.wraps !== 4'd0) begin errors++; $display("[TB] FAIL reset_wraps got %0d want 0", bus.wraps); end
        checks++; if (bus.at_min !== 1'b1) begin errors++; $display("[TB] FAIL reset_at_min got %b want 1", bus.at_min); end
    endtask

    task automatic test_wrap_up;
        bus.max_val = 8'd9; bus.up_dn = 1'b1; bus.sat_mode = 1'b0; bus.enable = 1'b1;
        for (int i = 1; i <= 10; i++) begin
            tick();
            checks++;
            if (bus.count !== DW'(i % 10)) begin errors++; $display("[TB] FAIL wrap_up_count step %0d got %0d want %0d", i, bus.count, i % 10); end
            checks++;
            if (bus.tc !== (i == 10)) begin errors++; $display("[TB] FAIL wrap_up_tc step %0d got %b want %b", i, bus.tc, i == 10); end
        end
        bus.enable = 1'b0;
        checks++; if (bus.wraps !== 4'd1) begin errors++; $display("[TB] FAIL wrap_up_wraps got %0d want 1", bus.wraps); end
    endtask

    task automatic test_sat_down;
        int pulses;
        int expect_seq[5] = '{2, 1, 0, 0, 0};
        pulses = 0;
        bus.max_val = 8'd9; bus.sat_mode = 1'b1; bus.up_dn = 1'b0;
        bus.load_val = 8'd2; bus.load = 1'b1; bus.enable = 1'b0;
        tick();
        bus.load = 1'b0;
        checks++; if (bus.count !== 8'd2) begin errors++; $display("[TB] FAIL sat_down_load got %0d want 2", bus.count); end
        bus.enable = 1'b1;
        for (int i = 1; i < 5; i++) begin
            tick();
            if (bus.tc === 1'b1) pulses++;
            checks++;
            if (bus.count !== DW'(expect_seq[i])) begin errors++; $display("[TB] FAIL sat_down_count step %0d got %0d want %0d", i, bus.count, expect_seq[i]); end
            checks++;
            if (bus.tc !== (i == 2)) begin errors++; $display("[TB] FAIL sat_down_tc step %0d got %b want %b", i, bus.tc, i == 2); end
        end
        bus.enable = 1'b0;
        checks++; if (pulses != 1) begin errors++; $display("[TB] FAIL sat_down_pulses got %0d want 1", pulses); end
    endtask

    task automatic test_load_clamp;
        bus.max_val = 8'd5; bus.load_val = 8'd12; bus.load = 1'b1;
        tick();
        checks++; if (bus.count !== 8'd5) begin errors++; $display("[TB] FAIL load_clamp_count got %0d want 5", bus.count); end
        checks++; if (bus.at_max !== 1'b1) begin errors++; $display("[TB] FAIL load_clamp_at_max got %b want 1", bus.at_max); end
        bus.clear = 1'b1;
        tick();
        bus.clear = 1'b0; bus.load = 1'b0;
        checks++; if (bus.count !== 8'd0) begin errors++; $display("[TB] FAIL clear_over_load got %0d want 0", bus.count); end
    endtask

    task automatic test_out_of_range;
        bus.max_val = 8'd255; bus.load_val = 8'd200; bus.load = 1'b1;
        tick();
        bus.load = 1'b0;
        checks++; if (bus.count !== 8'd200) begin errors++; $display("[TB] FAIL oor_load got %0d want 200", bus.count); end
        bus.max_val = 8'd50; bus.enable = 1'b1; bus.up_dn = 1'($urandom_range(0, 1)); bus.sat_mode = 1'($urandom_range(0, 1));
        tick();
        bus.enable = 1'b0;
        checks++; if (bus.count !== 8'd50) begin errors++; $display("[TB] FAIL oor_fix_count got %0d want 50", bus.count); end
        checks++; if (bus.tc !== 1'b0) begin errors++; $display("[TB] FAIL oor_fix_tc got %b want 0", bus.tc); end
    endtask

    task automatic test_zero_max;
        bus.max_val = 8'd0; bus.clear = 1'b1;
        tick();
        bus.clear = 1'b0; bus.sat_mode = 1'b0; bus.enable = 1'b1;
        for (int i = 0; i < 20; i++) begin
            bus.up_dn = 1'($urandom_range(0, 1));
            tick();
            checks++;
            if (bus.count !== 8'd0 || bus.tc !== 1'b1) begin errors++; $display("[TB] FAIL zero_max step %0d got count=%0d tc=%b want count=0 tc=1", i, bus.count, bus.tc); end
        end
        checks++; if (bus.wraps !== 4'd15) begin errors++; $display("[TB] FAIL zero_max_wraps got %0d want 15", bus.wraps); end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++;
        if (bus.count !== 8'd0 || bus.tc !== 1'b0 || bus.wraps !== 4'd0) begin
            errors++; $display("[TB] FAIL mid_reset got count=%0d tc=%b wraps=%0d want 0 0 0", bus.count, bus.tc, bus.wraps);
        end
        bus.sat_mode = 1'b1;
        tick();
        bus.enable = 1'b0;
        checks++; if (bus.count !== 8'd0 || bus.tc !== 1'b0) begin errors++; $display("[TB] FAIL zero_max_sat got count=%0d tc=%b want 0 0", bus.count, bus.tc); end
    endtask

    task automatic test_random;
        for (int i = 0; i < 600; i++) begin
            bus.enable   = ($urandom_range(0, 9) < 8);
            bus.up_dn    = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 15) == 0) bus.sat_mode = 1'($urandom_range(0, 1));
            bus.clear    = ($urandom_range(0, 39) == 0);
            bus.load     = ($urandom_range(0, 24) == 0);
            bus.load_val = DW'($urandom_range(0, 40));
            if ($urandom_range(0, 19) == 0)
                bus.max_val = ($urandom_range(0, 7) == 0) ? DW'($urandom_range(0, 255)) : DW'($urandom_range(0, 12));
            tick();
            checks++;
            if (bus.count !== DW'(m_count) || bus.tc !== 1'(m_tc) || bus.wraps !== WW'(m_wraps) ||
                bus.at_max !== (m_count == int'(bus.max_val)) || bus.at_min !== (m_count == 0)) begin
                errors++;
                $display("[TB] FAIL random cycle %0d got count=%0d tc=%b wraps=%0d max=%b min=%b want count=%0d tc=%0d wraps=%0d",
                         i, bus.count, bus.tc, bus.wraps, bus.at_max, bus.at_min, m_count, m_tc, m_wraps);
            end
        end
        bus.enable = 1'b0; bus.clear = 1'b0; bus.load = 1'b0;
    endtask

    initial begin
        m_count = 0; m_tc = 0; m_wraps = 0;
        rst = 1'b1;
        test_reset();
        test_wrap_up();
        test_sat_down();
        test_load_clamp();
        test_out_of_range();
        test_zero_max();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
